arbiter_sync_rr: RTL and testbench
==================================

# arbiter_sync_rr

Parametrised synchronous memory arbiter: successor to the fixed-priority 2^N arbiter. It multiplexes NCH clients (any count ≥ 2) onto one memory request port, selecting fixed-priority or round-robin arbitration via parameter. It uses back-to-back grants with a single idle cycle between transactions, and routes read data back to clients by ID. It sits between client blocks (display, DMA, CPU bridges) and the SDRAM/SRAM controller.

## Interface
- AN, 24: address width
- DN, 16: data width
- NCH, 4: number of clients, ≥ 2, need not be a power of two
- IDN, $clog2(NCH): ID width
- MODE, ARB_RR: arbitration mode, ARB_PRI (lowest index wins) or ARB_RR
- clkSYS  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- cli_req  in  [NCH]  client request; held until client samples cli_ack
- cli_addr  in  [NCH][AN]  client address
- cli_data  in  [NCH][DN]  client write data
- cli_wr  in  [NCH]  1 = write, 0 = read
- cli_ack  out  [NCH]  one-cycle pulse: request accepted by memory
- cli_valid  out  [NCH]  one-cycle pulse: cli_rdata holds read data for this client
- cli_rdata  out  DN  read data, broadcast to all clients
- mem_req  out  1  memory request
- mem_addr  out  AN  registered address of the granted client
- mem_data  out  DN  registered write data
- mem_wr  out  1  registered write flag
- mem_id  out  IDN  granted client index
- mem_ack  in  1  memory accepted current request
- mem_valid  in  1  read data valid
- mem_vid  in  IDN  ID of returned read data
- mem_rdata  in  DN  read data

## Operation
- States: IDLE, BUSY.
- IDLE: form eligible = cli_req & ~cli_ack. A client whose ack pulse is visible this cycle is masked.
  - If eligible is non-zero, pick a winner g. At the edge, register addr/data/wr of g, set mem_id←g and mem_req←1, and go to BUSY.
  - Otherwise stay in IDLE with mem_req=0.
- BUSY: hold mem_req and all mem_* stable until mem_ack is sampled high. At that edge: mem_req←0, cli_ack[mem_id]←1, go to IDLE.
- Winner selection:
  - ARB_PRI: lowest eligible index.
  - ARB_RR: first eligible index at or after ptr, wrapping modulo NCH. On each grant, ptr←(g+1) mod NCH, with the wrap computed explicitly because NCH may be a non-power of two.
- While idle, mem_addr/mem_data/mem_wr/mem_id hold their last values (no X).
- Read return: cli_valid[i]←mem_valid && mem_vid==i, and cli_rdata←mem_rdata every cycle mem_valid is high. Read returns are independent of the request FSM and may overlap a new grant.
- Boundaries:
  - mem_ack sampled while in IDLE: ignored, no cli_ack.
  - mem_valid with mem_vid ≥ NCH: dropped.
  - cli_req dropped by a client while it is in BUSY: no effect; the transaction completes and cli_ack still pulses.
  - Reset asserted mid-transaction: immediate return to IDLE. The memory side must be reset in the same domain.
- Client rule: deassert cli_req, or present a new request, no later than the edge at which cli_ack is sampled high.

## Timing
- Reset values: mem_req 0, mem_addr 0, mem_data 0, mem_wr 0, mem_id 0, cli_ack 0, cli_valid 0, cli_rdata 0, ptr 0, state IDLE.
- Request latency: cli_req high at edge k → mem_req high after edge k.
- Ack latency: mem_ack high at edge m → cli_ack high for exactly the cycle after edge m.
- Read latency: mem_valid at edge v → cli_valid and cli_rdata during the cycle after edge v.
- Throughput: with zero-wait memory (mem_ack on the first BUSY cycle), one grant every 2 cycles: BUSY, IDLE, BUSY.
- Two consecutive requests from the same client therefore need at least 3 cycles: the masked IDLE cycle blocks immediate re-grant.

## Structure
- arbiter_pkg:
  - typedef enum arb_mode_t {ARB_PRI, ARB_RR}
  - typedef enum arb_state_t {IDLE, BUSY}
  - function rr_next(idx, n) for modulo increment
- Sub-module arbiter_pick: combinational, parameters NCH and MODE. Inputs eligible and ptr; outputs found and g.
- arbiter_sync_rr holds the FSM, the registers, ptr and the return routing.

## Test plan
- NCH=3, ARB_RR, all cli_req held high, mem_ack on the first BUSY cycle → grant order 0,1,2,0,1,2 and a mem_req period of 2 cycles.
- NCH=4, ARB_PRI, cli_req=4'b1010 held high, client 1 deasserts after its ack → grants 1, then 3; client 3 is never granted while client 1 requests.
- Memory stalls 5 cycles before mem_ack, with a client changing cli_addr during the stall → mem_addr, mem_data, mem_wr and mem_id stay stable; cli_ack pulses for exactly 1 cycle.
- mem_valid=1, mem_vid=2, mem_rdata=16'hBEEF while a new grant is in progress → cli_valid=4'b0100 and cli_rdata=16'hBEEF the next cycle; the grant is unaffected. mem_vid=3 with NCH=3 → no cli_valid.
- Spurious mem_ack in IDLE → no cli_ack, state unchanged.
- n_reset pulsed low in BUSY → all outputs 0 asynchronously; after release, ptr=0 and the first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/arbiter_sync_rr_pkg.sv
// arbiter_sync_rr_pkg: shared arbitration mode/state types and the modulo increment helper.
package arbiter_sync_rr_pkg;

    typedef enum logic {ARB_PRI, ARB_RR} arb_mode_t;
    typedef enum logic {IDLE, BUSY} arb_state_t;

    // Explicit wrap so non-power-of-two client counts never alias onto a missing index.
    function automatic int rr_next(int idx, int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arbiter_sync_rr_if.sv
// arbiter_sync_rr_if: client and memory request/return bundle seen by the arbiter.
interface arbiter_sync_rr_if #(
    parameter int AN  = 24,
    parameter int DN  = 16,
    parameter int NCH = 4,
    parameter int IDN = $clog2(NCH)
);

    logic [NCH-1:0]         cli_req;
    logic [NCH-1:0][AN-1:0] cli_addr;
    logic [NCH-1:0][DN-1:0] cli_data;
    logic [NCH-1:0]         cli_wr;
    logic [NCH-1:0]         cli_ack;
    logic [NCH-1:0]         cli_valid;
    logic [DN-1:0]          cli_rdata;
    logic                   mem_req;
    logic [AN-1:0]          mem_addr;
    logic [DN-1:0]          mem_data;
    logic                   mem_wr;
    logic [IDN-1:0]         mem_id;
    logic                   mem_ack;
    logic                   mem_valid;
    logic [IDN-1:0]         mem_vid;
    logic [DN-1:0]          mem_rdata;

    modport slave (
        input  cli_req, cli_addr, cli_data, cli_wr, mem_ack, mem_valid, mem_vid, mem_rdata,
        output cli_ack, cli_valid, cli_rdata, mem_req, mem_addr, mem_data, mem_wr, mem_id
    );

    modport master (
        output cli_req, cli_addr, cli_data, cli_wr, mem_ack, mem_valid, mem_vid, mem_rdata,
        input  cli_ack, cli_valid, cli_rdata, mem_req, mem_addr, mem_data, mem_wr, mem_id
    );

endinterface

// File: rtl/arbiter_sync_rr_pick.sv
// arbiter_sync_rr_pick: combinational winner selection, fixed priority or round robin from ptr.
module arbiter_sync_rr_pick
    import arbiter_sync_rr_pkg::*;
#(
    parameter int        NCH  = 4,
    parameter arb_mode_t MODE = ARB_RR,
    parameter int        IDN  = $clog2(NCH)
) (
    input  logic [NCH-1:0] eligible,
    input  logic [IDN-1:0] ptr,
    output logic           found,
    output logic [IDN-1:0] g
);

    function automatic int slot(logic [IDN-1:0] base, int k);
        return (MODE == ARB_RR) ? ((int'(base) + k >= NCH) ? int'(base) + k - NCH : int'(base) + k) : k;
    endfunction

    always_comb begin
        found = 1'b0;
        g = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && eligible[slot(ptr, k)]) begin
                found = 1'b1;
                g = IDN'(slot(ptr, k));
            end
        end
    end

endmodule

// File: rtl/arbiter_sync_rr.sv
// arbiter_sync_rr: multiplexes NCH clients onto one memory port and routes read data back by ID.
module arbiter_sync_rr
    import arbiter_sync_rr_pkg::*;
#(
    parameter int        AN   = 24,
    parameter int        DN   = 16,
    parameter int        NCH  = 4,
    parameter int        IDN  = $clog2(NCH),
    parameter arb_mode_t MODE = ARB_RR
) (
    input logic              clkSYS,
    input logic              n_reset,
    arbiter_sync_rr_if.slave bus
);

    arb_state_t     state, state_nx;
    logic [IDN-1:0] ptr, g;
    logic [NCH-1:0] eligible;
    logic           found, grant, done;

    // A client whose ack is visible this cycle has not yet dropped its old request.
    assign eligible = bus.cli_req & ~bus.cli_ack;

    arbiter_sync_rr_pick #(.NCH(NCH), .MODE(MODE), .IDN(IDN)) u_pick (
        .eligible(eligible),
        .ptr(ptr),
        .found(found),
        .g(g)
    );

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant = 1'b0;
        done = 1'b0;
        if (state == IDLE) begin
            grant = found;
            state_nx = found ? BUSY : IDLE;
        end else begin
            done = bus.mem_ack;
            state_nx = bus.mem_ack ? IDLE : BUSY;
        end
    end

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            bus.mem_req <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
            bus.mem_wr <= 1'b0;
            bus.mem_id <= '0;
            bus.cli_ack <= '0;
            ptr <= '0;
        end else begin
            bus.cli_ack <= done ? NCH'(1) << bus.mem_id : '0;
            if (grant) begin
                bus.mem_req <= 1'b1;
                bus.mem_addr <= bus.cli_addr[g];
                bus.mem_data <= bus.cli_data[g];
                bus.mem_wr <= bus.cli_wr[g];
                bus.mem_id <= g;
                ptr <= IDN'(rr_next(int'(g), NCH));
            end else if (done) begin
                bus.mem_req <= 1'b0;
            end
        end
    end

    // Read return runs independently of the request FSM; out-of-range IDs are dropped.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            bus.cli_valid <= '0;
            bus.cli_rdata <= '0;
        end else begin
            bus.cli_valid <= (bus.mem_valid && int'(bus.mem_vid) < NCH) ? NCH'(1) << bus.mem_vid : '0;
            if (bus.mem_valid) bus.cli_rdata <= bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_arbiter_sync_rr.sv
// tb_arbiter_sync_rr: random clients and memory against a queue-based reference, NCH=3 RR and NCH=4 PRI.
module tb_arbiter_sync_rr;
    import arbiter_sync_rr_pkg::*;

    localparam int AN = 24;
    localparam int DN = 16;

    typedef struct {
        int            cyc;
        int            id;
        logic [AN-1:0] addr;
        logic [DN-1:0] data;
        logic          wr;
    } item_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   directed = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endfunction

    function automatic int ref_pick(int n, bit rr, int p, bit [7:0] el);
        for (int k = 0; k < n; k++) begin
            int i = rr ? (p + k) % n : k;
            if (el[i]) return i;
        end
        return -1;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : u
        localparam int        NCH  = k ? 4 : 3;
        localparam arb_mode_t MODE = k ? ARB_PRI : ARB_RR;
        localparam int        IDN  = $clog2(NCH);

        arbiter_sync_rr_if #(.AN(AN), .DN(DN), .NCH(NCH)) bus ();

        arbiter_sync_rr #(.AN(AN), .DN(DN), .NCH(NCH), .MODE(MODE)) dut (
            .clkSYS(clk),
            .n_reset(n_reset),
            .bus(bus)
        );

        item_t gq[$], aq[$], rq[$];
        item_t ge, e;
        int    ptr_m, cur;
        bit    busy, pr;
        bit [7:0] ack_vis;

        // Clients and memory stub.
        always @(negedge clk) begin
            bit fresh;
            if (!n_reset) begin
                bus.cli_req = '0;
                bus.cli_addr = '0;
                bus.cli_data = '0;
                bus.cli_wr = '0;
                bus.mem_ack = 1'b0;
                bus.mem_valid = 1'b0;
                bus.mem_vid = '0;
                bus.mem_rdata = '0;
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    fresh = 1'b0;
                    if (bus.cli_ack[i]) begin
                        bus.cli_req[i] = directed || $urandom_range(3) == 0;
                        fresh = 1'b1;
                    end else if (directed) begin
                        fresh = !bus.cli_req[i];
                        bus.cli_req[i] = 1'b1;
                    end else if (!bus.cli_req[i]) begin
                        bus.cli_req[i] = $urandom_range(2) == 0;
                        fresh = 1'b1;
                    end else if ($urandom_range(15) == 0) begin
                        bus.cli_req[i] = 1'b0;
                    end else begin
                        fresh = $urandom_range(3) == 0;
                    end
                    if (fresh) begin
                        bus.cli_addr[i] = AN'($urandom);
                        bus.cli_data[i] = DN'($urandom);
                        bus.cli_wr[i] = $urandom_range(1) == 1;
                    end
                end
                bus.mem_ack = directed ? 1'b1 : $urandom_range(3) == 0;
                bus.mem_valid = $urandom_range(2) == 0;
                bus.mem_vid = IDN'($urandom_range(2 ** IDN - 1));
                bus.mem_rdata = DN'($urandom);
            end
        end

        // Reference: grants, acks and read returns with the cycle each must be visible.
        always @(posedge clk or negedge n_reset) begin
            bit [7:0] el;
            int w;
            if (!n_reset) begin
                busy = 1'b0;
                ptr_m = 0;
                ack_vis = '0;
                gq.delete();
                aq.delete();
                rq.delete();
            end else begin
                el = 8'(bus.cli_req) & ~ack_vis;
                ack_vis = '0;
                if (!busy) begin
                    w = ref_pick(NCH, MODE == ARB_RR, ptr_m, el);
                    if (w >= 0) begin
                        gq.push_back('{cyc + 1, w, bus.cli_addr[w], bus.cli_data[w], bus.cli_wr[w]});
                        busy = 1'b1;
                        cur = w;
                        ptr_m = (w + 1) % NCH;
                    end
                end else if (bus.mem_ack) begin
                    busy = 1'b0;
                    ack_vis = 8'(1 << cur);
                    aq.push_back('{cyc + 1, cur, '0, '0, 1'b0});
                end
                if (bus.mem_valid && int'(bus.mem_vid) < NCH)
                    rq.push_back('{cyc + 1, int'(bus.mem_vid), '0, bus.mem_rdata, 1'b0});
            end
        end

        // Monitor: pops an expectation whenever the DUT shows an output or one falls due.
        always @(negedge clk) begin
            bit rise;
            if (!n_reset) begin
                pr = 1'b0;
            end else begin
                rise = bus.mem_req && !pr;
                pr = bus.mem_req;
                if (rise || (gq.size() != 0 && gq[0].cyc <= cyc)) begin
                    if (gq.size() == 0) chk($sformatf("u%0d grant_unexpected", k), 1, 0);
                    else begin
                        ge = gq.pop_front();
                        chk($sformatf("u%0d grant_edge", k), 64'(rise), 1);
                        chk($sformatf("u%0d grant_cycle", k), cyc, ge.cyc);
                        chk($sformatf("u%0d grant_id", k), bus.mem_id, ge.id);
                        chk($sformatf("u%0d grant_addr", k), bus.mem_addr, ge.addr);
                        chk($sformatf("u%0d grant_data", k), bus.mem_data, ge.data);
                        chk($sformatf("u%0d grant_wr", k), bus.mem_wr, ge.wr);
                    end
                end else if (bus.mem_req) begin
                    chk($sformatf("u%0d grant_hold", k), {bus.mem_id, bus.mem_wr, bus.mem_data, bus.mem_addr},
                        {IDN'(ge.id), ge.wr, ge.data, ge.addr});
                end
                if (bus.cli_ack != 0 || (aq.size() != 0 && aq[0].cyc <= cyc)) begin
                    if (aq.size() == 0) chk($sformatf("u%0d ack_unexpected", k), bus.cli_ack, 0);
                    else begin
                        e = aq.pop_front();
                        chk($sformatf("u%0d ack_cycle", k), cyc, e.cyc);
                        chk($sformatf("u%0d ack_vec", k), bus.cli_ack, 1 << e.id);
                    end
                end
                if (bus.cli_valid != 0 || (rq.size() != 0 && rq[0].cyc <= cyc)) begin
                    if (rq.size() == 0) chk($sformatf("u%0d rd_unexpected", k), bus.cli_valid, 0);
                    else begin
                        e = rq.pop_front();
                        chk($sformatf("u%0d rd_cycle", k), cyc, e.cyc);
                        chk($sformatf("u%0d rd_vec", k), bus.cli_valid, 1 << e.id);
                        chk($sformatf("u%0d rd_data", k), bus.cli_rdata, e.data);
                    end
                end
            end
        end
    end

    function automatic void check_zero(string tag);
        chk({tag, "_u0"}, 64'(|{u[0].bus.mem_req, u[0].bus.mem_addr, u[0].bus.mem_data, u[0].bus.mem_wr,
            u[0].bus.mem_id, u[0].bus.cli_ack, u[0].bus.cli_valid, u[0].bus.cli_rdata}), 0);
        chk({tag, "_u1"}, 64'(|{u[1].bus.mem_req, u[1].bus.mem_addr, u[1].bus.mem_data, u[1].bus.mem_wr,
            u[1].bus.mem_id, u[1].bus.cli_ack, u[1].bus.cli_valid, u[1].bus.cli_rdata}), 0);
    endfunction

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1 check_zero("reset_values");
        @(posedge clk);
        #2 n_reset = 1'b1;
        repeat (40) @(posedge clk);
        directed = 1'b0;
        repeat (3000) @(posedge clk);
        t = 0;
        do begin
            @(posedge clk);
            #2 t++;
        end while (!u[0].bus.mem_req && t < 100);
        chk("busy_before_reset", 64'(u[0].bus.mem_req), 1);
        n_reset = 1'b0;
        directed = 1'b1;
        #1 check_zero("async_reset");
        @(posedge clk);
        #2 n_reset = 1'b1;
        repeat (20) @(posedge clk);
        directed = 1'b0;
        repeat (300) @(posedge clk);
        #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
